// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared BIST state encoding and default MISR constants
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_APPLY,
        ST_CAPTURE,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

    // Also consumed by the TAP instruction decoder, so keep them in one place.
    localparam logic [15:0] BIST_POLY       = 16'h1021;
    localparam logic [15:0] BIST_SEED       = 16'hFFFF;
    localparam logic [15:0] BIST_GOLDEN_SIG = 16'h0000;

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - multiple-input signature register compressing CUT responses
module bist_misr
    import bist_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = BIST_POLY,
    parameter logic [SIG_W-1:0] SEED  = BIST_SEED
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load_seed,
    input  logic             shift_en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk) begin
        if (res || load_seed) begin
            sig <= SEED;
        end else if (shift_en) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
        end
    end

endmodule

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - BIST sequencer: pattern counter control, MISR capture, golden compare
// Optional BIST_CTRL_LOOP_EN adds loop input and fail_sticky output for continuous burn-in runs.
module bist_controller
    import bist_pkg::*;
#(
    parameter int               CNT_W         = 8,
    parameter int               SIG_W         = 16,
    parameter int unsigned      LAST_PATTERN  = 8'hFF,
    parameter int               SETTLE_CYCLES = 1,
    parameter logic [SIG_W-1:0] POLY          = BIST_POLY,
    parameter logic [SIG_W-1:0] SEED          = BIST_SEED,
    parameter logic [SIG_W-1:0] GOLDEN_SIG    = BIST_GOLDEN_SIG
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] counter_val,
    input  logic [SIG_W-1:0] cut_resp,
`ifdef BIST_CTRL_LOOP_EN
    input  logic             loop,
    output logic             fail_sticky,
`endif
    output logic             cnt_res,
    output logic             cnt_incr_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int               SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_VAL    = CNT_W'(LAST_PATTERN);

    bist_state_t      state, state_nxt;
    logic [SET_W-1:0] settle_cnt;
    logic             fault;
    logic             cnt_last, cnt_over, settle_done, run_ok;

    assign cnt_last    = (counter_val == LAST_VAL);
    assign cnt_over    = (counter_val > LAST_VAL);
    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign run_ok      = (signature == GOLDEN_SIG) && !fault;

    always_ff @(posedge clk) begin
        if (res || abort) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_CLEAR;
            ST_CLEAR:   state_nxt = ST_APPLY;
            ST_APPLY:   if (settle_done) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = (cnt_last || cnt_over) ? ST_COMPARE : ST_APPLY;
            ST_COMPARE: state_nxt = ST_DONE;
`ifdef BIST_CTRL_LOOP_EN
            ST_DONE:    if (start || loop) state_nxt = ST_CLEAR;
`else
            ST_DONE:    if (start) state_nxt = ST_CLEAR;
`endif
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // An out-of-range counter value never produces an increment, so the counter cannot wrap.
    assign cnt_res     = (state == ST_IDLE) || (state == ST_CLEAR);
    assign cnt_incr_en = (state == ST_CAPTURE) && !cnt_last && !cnt_over;
    assign busy        = (state == ST_CLEAR) || (state == ST_APPLY) ||
                         (state == ST_CAPTURE) || (state == ST_COMPARE);
    assign done        = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (res || abort || state == ST_CLEAR) begin
            settle_cnt <= '0;
        end else if (state == ST_APPLY) begin
            settle_cnt <= settle_done ? '0 : settle_cnt + 1'b1;
        end
    end

    // fault remembers a counter overrun so COMPARE can veto an otherwise matching signature.
    always_ff @(posedge clk) begin
        if (res || abort || state == ST_CLEAR) begin
            pass  <= 1'b0;
            fault <= 1'b0;
        end else if (state == ST_CAPTURE && cnt_over) begin
            fault <= 1'b1;
        end else if (state == ST_COMPARE) begin
            pass <= run_ok;
        end
    end

`ifdef BIST_CTRL_LOOP_EN
    always_ff @(posedge clk) begin
        if (res || abort) begin
            fail_sticky <= 1'b0;
        end else if (state == ST_COMPARE && !run_ok) begin
            fail_sticky <= 1'b1;
        end
    end
`endif

    bist_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk       (clk),
        .res       (res),
        .load_seed (abort || state == ST_CLEAR),
        .shift_en  (state == ST_CAPTURE),
        .din       (cut_resp),
        .sig       (signature)
    );

endmodule

// File: tb/tb_bist_controller.sv
// tb/tb_bist_controller.sv - randomized self-checking bench for bist_controller
module tb_bist_controller;

    localparam int LP  = 3;
    localparam int SC  = 1;
    localparam int LP0 = 0;
    localparam int SC0 = 2;
    localparam int LAT  = 2 + (LP + 1) * (SC + 1);
    localparam int LAT0 = 2 + (LP0 + 1) * (SC0 + 1);

    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    function automatic logic [15:0] ramp_sig(input int n);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int p = 0; p <= n; p++) s = misr_next(s, 16'(p));
        return s;
    endfunction

    localparam logic [15:0] GOLD  = ramp_sig(LP);
    localparam logic [15:0] GOLD0 = ramp_sig(LP0);

    logic        clk, res, start, abort, start0;
    logic        force_en;
    logic [7:0]  force_val, cnt, cnt0, counter_val;
    logic [15:0] resp_tab [256];
    logic [15:0] cut_resp, cut_resp0, signature, signature0;
    logic        cnt_res, cnt_incr_en, busy, done, pass;
    logic        cnt_res0, cnt_incr_en0, busy0, done0, pass0;
`ifdef BIST_CTRL_LOOP_EN
    logic        loop, fail_sticky, fail_sticky0;
`endif
    int checks, errors;

    assign counter_val = force_en ? force_val : cnt;
    assign cut_resp    = resp_tab[counter_val];
    assign cut_resp0   = resp_tab[cnt0];

    bist_controller #(.LAST_PATTERN(LP), .SETTLE_CYCLES(SC), .GOLDEN_SIG(GOLD)) dut (
        .clk(clk), .res(res), .start(start), .abort(abort),
        .counter_val(counter_val), .cut_resp(cut_resp),
`ifdef BIST_CTRL_LOOP_EN
        .loop(loop), .fail_sticky(fail_sticky),
`endif
        .cnt_res(cnt_res), .cnt_incr_en(cnt_incr_en), .busy(busy), .done(done),
        .pass(pass), .signature(signature)
    );

    bist_controller #(.LAST_PATTERN(LP0), .SETTLE_CYCLES(SC0), .GOLDEN_SIG(GOLD0)) dut0 (
        .clk(clk), .res(res), .start(start0), .abort(abort),
        .counter_val(cnt0), .cut_resp(cut_resp0),
`ifdef BIST_CTRL_LOOP_EN
        .loop(1'b0), .fail_sticky(fail_sticky0),
`endif
        .cnt_res(cnt_res0), .cnt_incr_en(cnt_incr_en0), .busy(busy0), .done(done0),
        .pass(pass0), .signature(signature0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural pattern counters seen by the two controllers.
    always @(posedge clk) begin
        if (cnt_res) cnt <= 8'd0;
        else if (cnt_incr_en) cnt <= cnt + 8'd1;
        if (cnt_res0) cnt0 <= 8'd0;
        else if (cnt_incr_en0) cnt0 <= cnt0 + 8'd1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int p = 0; p <= n; p++) s = misr_next(s, resp_tab[p]);
        return s;
    endfunction

    task automatic load_ramp();
        for (int i = 0; i < 256; i++) resp_tab[i] = 16'(i);
    endtask

    // Starts a run on dut and measures clocks to done and increment pulses seen.
    task automatic run(input string name, input int restart_at, output int lat, output int incrs);
        int ovl;
        lat = -1; incrs = 0; ovl = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start_ack got done=%b busy=%b want done=0 busy=1", name, done, busy);
        end
        for (int c = 0; c < 300; c++) begin
            if (done === 1'b1) begin lat = c; break; end
            if (cnt_incr_en === 1'b1) incrs++;
            if (cnt_incr_en === 1'b1 && cnt_res === 1'b1) ovl++;
            start = (c == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (ovl != 0) begin errors++; $display("FAIL %s res_incr_overlap got %0d want 0", name, ovl); end
    endtask

    task automatic test_reset();
        res = 1'b1;
        repeat (3) @(negedge clk);
        res = 1'b0;
        checks++;
        if ({done, busy, cnt_incr_en, cnt_res, pass} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_outputs got done,busy,incr,res,pass=%b want 00010", {done, busy, cnt_incr_en, cnt_res, pass});
        end
        checks++;
        if (signature !== 16'hFFFF) begin errors++; $display("FAIL reset_signature got %h want ffff", signature); end
        checks++;
        if ({done0, busy0, cnt_res0, signature0} !== {3'b001, 16'hFFFF}) begin
            errors++;
            $display("FAIL reset_dut0 got done=%b busy=%b res=%b sig=%h", done0, busy0, cnt_res0, signature0);
        end
    endtask

    task automatic test_nominal(input string name, input int restart_at);
        int lat, incrs;
        load_ramp();
        run(name, restart_at, lat, incrs);
        checks++; if (lat != LAT) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, LAT); end
        checks++; if (incrs != LP) begin errors++; $display("FAIL %s incr_pulses got %0d want %0d", name, incrs, LP); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL %s pass got %b want 1", name, pass); end
        checks++; if (signature !== GOLD) begin errors++; $display("FAIL %s signature got %h want %h", name, signature, GOLD); end
    endtask

    task automatic test_corrupt();
        int lat, incrs;
        load_ramp();
        resp_tab[2] = resp_tab[2] ^ 16'h0001;
        run("corrupt", -1, lat, incrs);
        checks++; if (lat != LAT) begin errors++; $display("FAIL corrupt latency got %0d want %0d", lat, LAT); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL corrupt pass got %b want 0", pass); end
        checks++;
        if (signature !== model_sig(LP) || signature === GOLD) begin
            errors++;
            $display("FAIL corrupt signature got %h want %h (not %h)", signature, model_sig(LP), GOLD);
        end
    endtask

    task automatic test_random();
        int lat, incrs;
        logic [15:0] exp_sig;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) resp_tab[i] = 16'($urandom);
            if (r == 3) load_ramp();
            exp_sig = model_sig(LP);
            run("random", -1, lat, incrs);
            checks++; if (lat != LAT) begin errors++; $display("FAIL random%0d latency got %0d want %0d", r, lat, LAT); end
            checks++; if (signature !== exp_sig) begin errors++; $display("FAIL random%0d signature got %h want %h", r, signature, exp_sig); end
            checks++;
            if (pass !== (exp_sig == GOLD)) begin errors++; $display("FAIL random%0d pass got %b want %b", r, pass, exp_sig == GOLD); end
        end
    endtask

    task automatic test_abort();
        int n;
        load_ramp();
        n = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (cnt_incr_en === 1'b1) n++;
            if (n == 2) break;
            @(negedge clk);
        end
        checks++; if (n != 2) begin errors++; $display("FAIL abort second_incr got %0d pulses want 2", n); end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if ({busy, done, cnt_res, cnt_incr_en, pass} !== 5'b00100) begin
            errors++;
            $display("FAIL abort_state got busy,done,res,incr,pass=%b want 00100", {busy, done, cnt_res, cnt_incr_en, pass});
        end
        checks++; if (signature !== 16'hFFFF) begin errors++; $display("FAIL abort_signature got %h want ffff", signature); end
        @(negedge clk);
        checks++; if (counter_val !== 8'd0) begin errors++; $display("FAIL abort_counter got %0d want 0", counter_val); end
        test_nominal("after_abort", -1);
    endtask

    task automatic test_res_mid_run();
        load_ramp();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        res = 1'b1;
        @(negedge clk); res = 1'b0;
        checks++;
        if ({busy, done, cnt_res} !== 3'b001 || signature !== 16'hFFFF) begin
            errors++;
            $display("FAIL res_mid_run got busy=%b done=%b res=%b sig=%h want 0 0 1 ffff", busy, done, cnt_res, signature);
        end
    endtask

    task automatic test_counter_fault();
        int lat, incrs;
        logic [15:0] exp_sig;
        load_ramp();
        force_val = 8'($urandom_range(255, LP + 1));
        // Response chosen so the signature matches golden; only the fault may fail the run.
        resp_tab[force_val] = GOLD ^ misr_next(16'hFFFF, 16'h0000);
        exp_sig = misr_next(16'hFFFF, resp_tab[force_val]);
        force_en = 1'b1;
        run("counter_fault", -1, lat, incrs);
        force_en = 1'b0;
        checks++; if (lat != 4) begin errors++; $display("FAIL fault latency got %0d want 4", lat); end
        checks++; if (incrs != 0) begin errors++; $display("FAIL fault incr_pulses got %0d want 0", incrs); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL fault pass got %b want 0", pass); end
        checks++; if (signature !== exp_sig) begin errors++; $display("FAIL fault signature got %h want %h", signature, exp_sig); end
    endtask

    task automatic test_single_pattern();
        int lat, incrs;
        load_ramp();
        lat = -1; incrs = 0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (done0 === 1'b1) begin lat = c; break; end
            if (cnt_incr_en0 === 1'b1) incrs++;
            @(negedge clk);
        end
        checks++; if (lat != LAT0) begin errors++; $display("FAIL lp0 latency got %0d want %0d", lat, LAT0); end
        checks++; if (incrs != 0 || cnt0 !== 8'd0) begin errors++; $display("FAIL lp0 incr got %0d cnt %0d want 0 0", incrs, cnt0); end
        checks++;
        if (pass0 !== 1'b1 || signature0 !== GOLD0) begin
            errors++;
            $display("FAIL lp0 result got pass=%b sig=%h want 1 %h", pass0, signature0, GOLD0);
        end
    endtask

`ifdef BIST_CTRL_LOOP_EN
    task automatic test_loop();
        int k;
        int d_cyc [3];
        logic p [3];
        logic fs [3];
        load_ramp();
        k = 0;
        loop = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 100 && k < 3; c++) begin
            if (done === 1'b1) begin
                d_cyc[k] = c; p[k] = pass; fs[k] = fail_sticky; k++;
                if (k == 1 || k == 2) resp_tab[2] = resp_tab[2] ^ 16'h0001;
            end
            if (k < 3) @(negedge clk);
        end
        loop = 1'b0;
        checks++; if (k != 3) begin errors++; $display("FAIL loop runs got %0d want 3", k); end
        for (int i = 0; i < k; i++) begin
            checks++;
            if (d_cyc[i] != LAT + i * (LAT + 1) || p[i] !== (i != 1) || fs[i] !== (i != 0)) begin
                errors++;
                $display("FAIL loop run%0d got cyc=%0d pass=%b sticky=%b want %0d %b %b",
                         i, d_cyc[i], p[i], fs[i], LAT + i * (LAT + 1), i != 1, i != 0);
            end
        end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++; if (fail_sticky !== 1'b0) begin errors++; $display("FAIL loop sticky_abort got %b want 0", fail_sticky); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        res = 1'b1; start = 1'b0; start0 = 1'b0; abort = 1'b0;
        force_en = 1'b0; force_val = 8'd0;
`ifdef BIST_CTRL_LOOP_EN
        loop = 1'b0;
`endif
        load_ramp();
        test_reset();
        test_nominal("nominal", -1);
        test_corrupt();
        test_random();
        test_nominal("start_mid_run", 4);
        test_abort();
        test_res_mid_run();
        test_counter_fault();
        test_nominal("after_fault", -1);
        test_single_pattern();
`ifdef BIST_CTRL_LOOP_EN
        test_loop();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
